// File: rtl/sub_bytes_seq.sv
// rtl/sub_bytes_seq.sv - time-multiplexed AES forward SubBytes engine with valid/ready handshakes
module sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int K  = 16 / LANES;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST_GRP = CW'(K - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] grp;
  logic [127:0]  work, work_next;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse is x^254 (so 0 maps to 0), followed by the FIPS-197 affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] base;
    logic [7:0] e;
    r    = 8'h01;
    base = x;
    e    = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // Substitute the LANES bytes of the current group; byte 0 sits in the top bits.
  always_comb begin
    int idx;
    idx       = 0;
    work_next = work;
    for (int l = 0; l < LANES; l++) begin
      idx = int'(grp) * LANES + l;
      work_next[127 - 8*idx -: 8] = sbox(work[127 - 8*idx -: 8]);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: accept in IDLE, walk the groups in RUN, hold in DONE until consumed.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (grp == LAST_GRP) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Working register and group counter; the counter saturates at the last group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= 128'h0;
      grp  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work <= in_state;
          grp  <= '0;
        end
        RUN: begin
          work <= work_next;
          if (grp != LAST_GRP) grp <= grp + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_state = work;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// tb/tb_sub_bytes_seq.sv - randomized and directed checks of sub_bytes_seq for LANES 1, 4 and 16
module tb_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_state = 128'h0;
  logic [2:0]   in_ready_v, out_valid_v, busy_v;
  logic [127:0] out_state_v [3];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  logic [7:0]   s_t   [256];
  logic [7:0]   inv_t [256];
  bit           pend  [3] = '{1'b0, 1'b0, 1'b0};
  int           age   [3] = '{0, 0, 0};
  logic [127:0] expv  [3];
  logic [127:0] cap   [3];

  localparam logic [127:0] ALL63 = {16{8'h63}};

  always #5 clk = ~clk;

  sub_bytes_seq #(.LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .in_state(in_state), .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .out_state(out_state_v[0]), .busy(busy_v[0]));

  sub_bytes_seq #(.LANES(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .in_state(in_state), .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .out_state(out_state_v[1]), .busy(busy_v[1]));

  sub_bytes_seq #(.LANES(16)) u_l16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .in_state(in_state), .out_valid(out_valid_v[2]), .out_ready(out_ready),
    .out_state(out_state_v[2]), .busy(busy_v[2]));

  function automatic int kof(input int i);
    return (i == 0) ? 16 : (i == 1) ? 4 : 1;
  endfunction

  function automatic logic [127:0] sub128(input logic [127:0] x);
    logic [127:0] y;
    y = 128'h0;
    for (int b = 0; b < 16; b++) y[127 - 8*b -: 8] = s_t[x[127 - 8*b -: 8]];
    return y;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Transaction timeline per instance: a block is pending from acceptance; K edges later it is
  // presented, and it leaves on the first edge with out_ready high.
  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i]) begin
          if (in_valid) begin
            pend[i] = 1'b1;
            age[i]  = 0;
            expv[i] = sub128(in_state);
          end
        end else if (age[i] < kof(i)) begin
          age[i] = age[i] + 1;
        end else if (out_ready) begin
          pend[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge rst_n) begin
    for (int i = 0; i < 3; i++) pend[i] = 1'b0;
  end

  // Every cycle: compare handshake/busy flags and, when presented, the data against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          chk($sformatf("rst_ctl_L%0d", 16 / kof(i)), {125'h0, in_ready_v[i], out_valid_v[i], busy_v[i]}, 128'h4);
          chk($sformatf("rst_data_L%0d", 16 / kof(i)), out_state_v[i], 128'h0);
        end else begin
          logic [2:0] e;
          e = !pend[i] ? 3'b100 : (age[i] < kof(i)) ? 3'b001 : 3'b011;
          chk($sformatf("ctl_L%0d", 16 / kof(i)), {125'h0, in_ready_v[i], out_valid_v[i], busy_v[i]}, {125'h0, e});
          if (pend[i] && age[i] == kof(i))
            chk($sformatf("data_L%0d", 16 / kof(i)), out_state_v[i], expv[i]);
        end
      end
    end
  end

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic run_vec(input logic [127:0] v, input logic [127:0] want, input string name);
    logic [2:0] got;
    bit         dropped;
    int         n;
    drain();
    in_state = v;
    in_valid = 1'b1;
    got      = 3'b000;
    dropped  = 1'b0;
    n        = 0;
    while (got != 3'b111 && n < 60) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < 3; i++) begin
        if (out_valid_v[i] && !got[i]) begin
          got[i] = 1'b1;
          cap[i] = out_state_v[i];
          chk($sformatf("%s_L%0d", name, 16 / kof(i)), cap[i], want);
        end
      end
      if (!dropped && pend[0] && pend[1] && pend[2]) begin
        dropped  = 1'b1;
        in_valid = 1'b0;
        in_state = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    if (got != 3'b111) chk({name, "_timeout"}, {125'h0, got}, 128'h7);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0]   p, q, x;
    logic [127:0] a, b, v, rec;
    int           n;

    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      s_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    s_t[0] = 8'h63;
    for (int k = 0; k < 256; k++) inv_t[s_t[k]] = 8'(k);

    chk("model_s00", {120'h0, s_t[8'h00]}, 128'h63);
    chk("model_s53", {120'h0, s_t[8'h53]}, 128'hed);
    chk("model_sff", {120'h0, s_t[8'hff]}, 128'h16);
    chk("model_appb", sub128(128'h193de3bea0f4e22b9ac68d2ae9f84808), 128'hd42711aee0bf98f1b8b45de51e415230);

    chk_on = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      in_state  = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;

    run_vec(128'h0, ALL63, "zeros");
    run_vec(128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230, "appb");
    run_vec(128'h52096b92247d00017f4f36ff52096b92, 128'h00017f4f36ff637cd284051600017f4f, "invx");

    for (int j = 0; j < 16; j++) begin
      for (int bb = 0; bb < 16; bb++) v[127 - 8*bb -: 8] = 8'(16*j + bb);
      run_vec(v, sub128(v), "sweep");
      for (int i = 0; i < 3; i++) begin
        for (int bb = 0; bb < 16; bb++) rec[127 - 8*bb -: 8] = inv_t[cap[i][127 - 8*bb -: 8]];
        chk($sformatf("inv_sweep_L%0d", 16 / kof(i)), rec, v);
      end
    end

    // Backpressure: hold out_ready low while new data is offered.
    drain();
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    in_state  = a;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    n = 0;
    while (out_valid_v != 3'b111 && n < 40) begin
      @(negedge clk);
      n++;
      if (in_ready_v == 3'b000) in_state = b;
    end
    if (out_valid_v != 3'b111) chk("bp_timeout", {125'h0, out_valid_v}, 128'h7);
    in_state = b;
    repeat (10) @(negedge clk);
    chk("bp_hold_L4", out_state_v[1], sub128(a));
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_rdy", {125'h0, in_ready_v}, 128'h7);
    @(negedge clk);
    chk("bp_next_accept", {125'h0, in_ready_v[1], busy_v[1]}, 128'h1);
    in_valid = 1'b0;

    // Reset in the middle of RUN on the LANES=4 instance (group 2).
    drain();
    in_state = 128'h0;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (in_ready_v[1] && n < 20);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midrst_ctl_L%0d", 16 / kof(i)), {125'h0, in_ready_v[i], out_valid_v[i], busy_v[i]}, 128'h4);
      chk($sformatf("midrst_data_L%0d", 16 / kof(i)), out_state_v[i], 128'h0);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    run_vec(128'h0, ALL63, "post_rst_zeros");

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_state  = {$urandom, $urandom, $urandom, $urandom};
    end
    drain();

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
